// File: rtl/fifo_ff_arbiter_if.sv
// Bundle of the source, FIFO-write, FIFO-read and status signals around fifo_ff_arbiter.
// The master modport is the arbiter's view; the slave modport is the sources/FIFO/status side.
interface fifo_ff_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2048
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    // A beat moves on a cycle where valid and ready are both 1 at the rising edge.
    // valid never waits on ready. A beat that is offered but not taken stays on the bus unchanged.
    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data;
    logic [NUM_SRC-1:0]            s_axis_valid;
    logic [NUM_SRC-1:0]            s_axis_last;
    logic [NUM_SRC-1:0]            s_axis_ready;

    logic                  f_wr_en;
    logic [DATA_WIDTH-1:0] f_data;
    logic                  f_valid;
    logic                  f_last;
    logic                  f_ready;
    logic                  f_full;
    logic                  f_empty;
    logic                  m_ready;
    logic                  f_rd_en;

    logic             grant_valid;
    logic [2:0]       grant_id;
    logic [OCC_W-1:0] occupancy;
    logic             pkt_err;

    modport master (
        input  s_axis_data, s_axis_valid, s_axis_last, f_ready, f_full, f_empty, m_ready,
        output s_axis_ready, f_wr_en, f_data, f_valid, f_last, f_rd_en,
               grant_valid, grant_id, occupancy, pkt_err
    );

    modport slave (
        output s_axis_data, s_axis_valid, s_axis_last, f_ready, f_full, f_empty, m_ready,
        input  s_axis_ready, f_wr_en, f_data, f_valid, f_last, f_rd_en,
               grant_valid, grant_id, occupancy, pkt_err
    );
endinterface

// File: rtl/fifo_ff_arbiter.sv
// Packet-locked round-robin arbiter and sequencer in front of the fifo_ff buffer.
// Define FIFO_ARB_PRIO_EN to give source 0 strict priority over a round-robin of sources 1..NUM_SRC-1.
module fifo_ff_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 2048,
    parameter int MAX_PKT_LEN = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    fifo_ff_arbiter_if.master bus,
    output logic              fsm_state
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

`ifdef FIFO_ARB_PRIO_EN
    localparam logic [NUM_SRC-1:0] RR_MASK = {{(NUM_SRC-1){1'b1}}, 1'b0};
    localparam logic [2:0]         PTR_RST = 3'd1;
`else
    localparam logic [NUM_SRC-1:0] RR_MASK = '1;
    localparam logic [2:0]         PTR_RST = 3'd0;
`endif

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       gid_q, gid_d;
    logic             gvalid_q, gvalid_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             err_q, err_d;

    logic                  sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_SRC-1:0]    ready_vec, rr_valid;
    logic                  xfer_ok, accept, at_max, last_out, rd_en;
    logic                  hi_found, lo_found, pick_found;
    logic [2:0]            hi_id, lo_id, pick_id, next_ptr;

    // Mux of the granted source. The loop keeps every index constant.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        ready_vec = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (gid_q == 3'(j)) begin
                sel_valid    = bus.s_axis_valid[j];
                sel_last     = bus.s_axis_last[j];
                sel_data     = bus.s_axis_data[j*DATA_WIDTH +: DATA_WIDTH];
                ready_vec[j] = xfer_ok;
            end
        end
    end

    assign xfer_ok  = (state_q == XFER) & bus.f_ready & ~bus.f_full;
    assign accept   = xfer_ok & sel_valid;
    assign at_max   = (beat_q == CNT_W'(MAX_PKT_LEN - 1));
    assign last_out = (state_q == XFER) & (sel_last | at_max);
    assign rd_en    = enable & bus.m_ready & ~bus.f_empty & ~reset_n;
    assign rr_valid = bus.s_axis_valid & RR_MASK;

    // Round-robin pick: lowest valid index at or above the pointer, else lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (rr_valid[j]) begin
                lo_found = 1'b1;
                lo_id    = 3'(j);
                if (3'(j) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = 3'(j);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_id    = hi_found ? hi_id : lo_id;
`ifdef FIFO_ARB_PRIO_EN
        if (bus.s_axis_valid[0]) begin
            pick_found = 1'b1;
            pick_id    = 3'd0;
        end
`endif
    end

    always_comb begin
        if (gid_q == 3'(NUM_SRC - 1)) next_ptr = PTR_RST;
        else                          next_ptr = gid_q + 3'd1;
`ifdef FIFO_ARB_PRIO_EN
        // A priority grant to source 0 leaves the round-robin position alone.
        if (gid_q == 3'd0) next_ptr = ptr_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        gvalid_d = gvalid_q;
        beat_d   = beat_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    state_d  = XFER;
                    gid_d    = pick_id;
                    gvalid_d = 1'b1;
                    beat_d   = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    if (last_out) begin
                        state_d  = IDLE;
                        gvalid_d = 1'b0;
                        beat_d   = '0;
                        ptr_d    = next_ptr;
                        if (at_max && !sel_last) err_d = 1'b1;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating occupancy; a simultaneous write and read cancel out.
    always_comb begin
        occ_d = occ_q;
        if (accept && !rd_en && occ_q != OCC_W'(DEPTH)) occ_d = occ_q + OCC_W'(1);
        else if (rd_en && !accept && occ_q != '0)       occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_RST;
            gid_q    <= '0;
            gvalid_q <= 1'b0;
            beat_q   <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            gvalid_q <= gvalid_d;
            beat_q   <= beat_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    assign bus.s_axis_ready = ready_vec;
    assign bus.f_wr_en      = accept;
    assign bus.f_data       = sel_data;
    assign bus.f_valid      = (state_q == XFER) & sel_valid;
    assign bus.f_last       = last_out;
    assign bus.f_rd_en      = rd_en;
    assign bus.grant_valid  = gvalid_q;
    assign bus.grant_id     = gid_q;
    assign bus.occupancy    = occ_q;
    assign bus.pkt_err      = err_q;
    assign fsm_state        = state_q;
endmodule

// File: tb/tb_fifo_ff_arbiter.sv
// Directed bench for fifo_ff_arbiter built with MAX_PKT_LEN=4, so packet truncation is reachable.
// Every written beat is checked against a queue of expected {last, grant_id, data} words.
module tb_fifo_ff_arbiter;
    localparam int NUM_SRC = 4;
    localparam int DW      = 32;
    localparam int DEPTH   = 2048;
    localparam int MAXP    = 4;
    localparam int SBW     = 1 + 3 + DW;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic fsm_state;

    int total = 0;
    int bad   = 0;

    logic [SBW-1:0] exp_q[$];
    int   wr_cnt    = 0;
    int   cyc       = 0;
    int   last_end  = 0;
    logic prev_last = 1'b0;
    logic gap_chk   = 1'b0;

    fifo_ff_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_ff_arbiter #(
        .NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_PKT_LEN(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(bus), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int src, input logic [DW-1:0] data, input logic last);
        exp_q.push_back({last, 3'(src), data});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int src, input logic [DW-1:0] base, input int n, input int last_at);
        logic acc;
        int   guard;
        for (int b = 0; b < n; b++) begin
            bus.s_axis_data[src*DW +: DW] = base + DW'(b);
            bus.s_axis_last[src]  = (b == last_at - 1);
            bus.s_axis_valid[src] = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                acc = bus.s_axis_ready[src];
                guard++;
            end while (!acc && guard < 300);
            if (!acc) check("accept_timeout", acc, 1);
            step();
        end
        bus.s_axis_valid[src] = 1'b0;
        bus.s_axis_last[src]  = 1'b0;
    endtask

    // Scoreboard: compares every written beat and, while gap_chk is set, the spacing of back-to-back packets.
    always @(negedge clk) begin
        cyc++;
        if (bus.f_wr_en === 1'b1) begin
            wr_cnt++;
            if (gap_chk && prev_last && last_end != 0) check("rr_gap", cyc - last_end, 2);
            if (exp_q.size() > 0) check("sb_beat", {bus.f_last, bus.grant_id, bus.f_data}, exp_q.pop_front());
            else                  check("sb_underflow", exp_q.size(), 1);
            prev_last = bus.f_last;
            if (bus.f_last) last_end = gap_chk ? cyc : 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        reset_n          = 1'b1;
        enable           = 1'b1;
        bus.s_axis_data  = '0;
        bus.s_axis_valid = '0;
        bus.s_axis_last  = '0;
        bus.f_ready      = 1'b1;
        bus.f_full       = 1'b0;
        bus.f_empty      = 1'b1;
        bus.m_ready      = 1'b0;

        // Reset, then idle
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.s_axis_ready, 0);
        check("rst_gvalid", bus.grant_valid, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_rd_en", bus.f_rd_en, 0);
        check("rst_err", bus.pkt_err, 0);
        check("rst_state", fsm_state, 0);

        // Single packet from source 2
        step();
        for (int b = 0; b < 4; b++) push(2, 32'hA0 + 32'(b), b == 3);
        fork
            send_pkt(2, 32'hA0, 4, 4);
            begin
                @(negedge clk);
                check("arb_idle_gvalid", bus.grant_valid, 0);
                check("arb_idle_wr", bus.f_wr_en, 0);
                @(negedge clk);
                check("grant_valid", bus.grant_valid, 1);
                check("grant_id", bus.grant_id, 2);
                check("ready_onehot", bus.s_axis_ready, 4'b0100);
            end
        join
        check("single_end_gvalid", bus.grant_valid, 0);
        check("single_end_state", fsm_state, 0);
        check("single_occ", bus.occupancy, 4);
        check("single_wr_cnt", wr_cnt, 4);

        // Round-robin between sources 0 and 1; the pointer sits at 3, so source 0 is first
        push(0, 32'hB0, 0); push(0, 32'hB1, 1);
        push(1, 32'hC0, 0); push(1, 32'hC1, 1);
        push(0, 32'hB2, 0); push(0, 32'hB3, 1);
        push(1, 32'hC2, 0); push(1, 32'hC3, 1);
        gap_chk = 1'b1;
        fork
            begin send_pkt(0, 32'hB0, 2, 2); send_pkt(0, 32'hB2, 2, 2); end
            begin send_pkt(1, 32'hC0, 2, 2); send_pkt(1, 32'hC2, 2, 2); end
        join
        gap_chk = 1'b0;
        check("rr_occ", bus.occupancy, 12);
        check("rr_wr_cnt", wr_cnt, 12);

        // FIFO full for 5 cycles in mid-packet, with enable low as well
        for (int b = 0; b < 4; b++) push(3, 32'hD0 + 32'(b), b == 3);
        fork
            send_pkt(3, 32'hD0, 4, 4);
            begin
                g = 0;
                while (wr_cnt < 14 && g < 100) begin
                    @(negedge clk);
                    #1;
                    g++;
                end
                check("bp_reach", wr_cnt, 14);
                step();
                bus.f_full = 1'b1;
                enable     = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_ready", bus.s_axis_ready, 0);
                    check("bp_wr_en", bus.f_wr_en, 0);
                    check("bp_hold", {bus.grant_valid, bus.grant_id}, {1'b1, 3'd3});
                end
                step();
                bus.f_full = 1'b0;
                enable     = 1'b1;
            end
        join
        check("bp_occ", bus.occupancy, 16);
        check("bp_wr_cnt", wr_cnt, 16);

        // Reads: 6 reads bring occupancy to 10
        bus.m_ready = 1'b1;
        bus.f_empty = 1'b0;
        @(negedge clk);
        check("rd_en_on", bus.f_rd_en, 1);
        repeat (6) @(posedge clk);
        #1 bus.m_ready = 1'b0;
        check("rd_occ10", bus.occupancy, 10);

        // Reads during a 3-beat packet: only the arbitration cycle removes one beat
        for (int b = 0; b < 3; b++) push(0, 32'h50 + 32'(b), b == 2);
        bus.m_ready = 1'b1;
        send_pkt(0, 32'h50, 3, 3);
        bus.m_ready = 1'b0;
        check("rw_simul_occ", bus.occupancy, 9);

        // enable=0 blocks the read enable
        enable      = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("rd_en_dis", bus.f_rd_en, 0);
        step();
        check("rd_dis_occ", bus.occupancy, 9);
        enable = 1'b1;
        @(negedge clk);
        check("rd_en_reen", bus.f_rd_en, 1);
        step();
        bus.m_ready = 1'b0;
        bus.f_empty = 1'b1;
        check("rd_reen_occ", bus.occupancy, 8);

        // Truncation: 6 beats with MAX_PKT_LEN=4, and no grant while enable is low
        check("err_before", bus.pkt_err, 0);
        push(1, 32'h60, 0); push(1, 32'h61, 0); push(1, 32'h62, 0); push(1, 32'h63, 1);
        push(1, 32'h64, 0); push(1, 32'h65, 1);
        enable = 1'b0;
        fork
            send_pkt(1, 32'h60, 6, 6);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("en_off_nogrant", bus.grant_valid, 0);
                end
                step();
                enable = 1'b1;
            end
        join
        check("trunc_err", bus.pkt_err, 1);
        check("trunc_occ", bus.occupancy, 14);
        check("trunc_wr_cnt", wr_cnt, 25);
        check("sb_drain", exp_q.size(), 0);

        // Reset clears the sticky error and the occupancy
        reset_n = 1'b1;
        step();
        reset_n = 1'b0;
        @(negedge clk);
        check("rst2_err", bus.pkt_err, 0);
        check("rst2_occ", bus.occupancy, 0);
        check("rst2_gvalid", bus.grant_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_ff_arbiter.md
Name: fifo_ff_arbiter

Overview:
Packet-level round-robin arbiter and sequencer for the 2048-deep fifo_ff buffer. It multiplexes NUM_SRC AXI-Stream sources onto the single FIFO write port, locking the grant until the packet's last beat. It drives the FIFO read enable from downstream readiness and the FIFO empty flag. It enforces a maximum packet length, and exposes grant, occupancy and error status.

Parameters:
NUM_SRC, 4, number of requesting AXI-Stream sources (2..8)
DATA_WIDTH, 32, beat width; must match the FIFO
DEPTH, 2048, FIFO depth; occupancy counter width is clog2(DEPTH)+1
MAX_PKT_LEN, 256, maximum number of beats per packet before a forced last

Ports:
clk  in  1  single clock; all logic is rising-edge
reset_n  in  1  synchronous, active-high reset (asserted = 1); the name is kept for codebase consistency
enable  in  1  when 0: no new grants and f_rd_en is held 0; an in-flight packet completes
s_axis_data  in  NUM_SRC*DATA_WIDTH  source data, packed; src i occupies [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_valid  in  NUM_SRC  per-source valid
s_axis_last  in  NUM_SRC  per-source last
s_axis_ready  out  NUM_SRC  per-source ready; at most one bit set
f_wr_en  out  1  FIFO write enable
f_data  out  DATA_WIDTH  data to the FIFO
f_valid  out  1  valid to the FIFO
f_last  out  1  last to the FIFO (source last OR forced last)
f_ready  in  1  FIFO s_axis_ready
f_full  in  1  FIFO full
f_empty  in  1  FIFO empty
m_ready  in  1  downstream ready
f_rd_en  out  1  FIFO read enable
grant_valid  out  1  a source is currently granted
grant_id  out  3  index of the granted source
occupancy  out  12  beats written minus beats read
pkt_err  out  1  sticky; set on forced truncation, cleared only by reset

Behaviour:
- Reset (reset_n=1 at a clock edge): the FSM goes to IDLE and the round-robin pointer goes to 0. beat_cnt, occupancy, pkt_err, grant_valid and grant_id all go to 0. All s_axis_ready bits, f_wr_en, f_valid, f_last and f_rd_en go to 0. A packet in flight is abandoned; its tail beats are not accepted until a new grant.
- FSM states are IDLE and XFER.
- IDLE: if enable=1 and any s_axis_valid is set, pick the first valid source at or after the pointer, wrapping modulo NUM_SRC.
  - grant_id and grant_valid are registered, and the FSM moves to XFER.
  - Arbitration costs exactly 1 cycle: no beat is accepted in IDLE.
- XFER: s_axis_ready[grant_id] = f_ready & ~f_full (combinational); all other ready bits are 0.
  - f_valid = s_axis_valid[grant_id].
  - f_wr_en = s_axis_valid[g] & s_axis_ready[g].
  - f_data is a combinational mux of the granted source.
- Accepted beat: beat_cnt increments.
  - If beat_cnt = MAX_PKT_LEN-1 and the source's last is 0, f_last is forced to 1 and pkt_err is set. The grant then ends; the source's remaining beats form a new packet on its next grant.
- On an accepted beat with f_last=1: go to IDLE, set pointer = (grant_id+1) mod NUM_SRC, clear beat_cnt and grant_valid.
  - Back-to-back packets therefore see 1 idle cycle between them.
- enable dropping mid-packet does not break the grant.
- Read side: f_rd_en = enable & m_ready & ~f_empty (combinational).
- occupancy update per cycle: +1 on f_wr_en, -1 on f_rd_en, unchanged when both occur. It never goes below 0 or above DEPTH.
- f_full=1 holds ready low with no beat lost; the grant is held until space frees.
- A source dropping valid mid-packet keeps the grant; there is no timeout.

Optional Feature:
FIFO_ARB_PRIO_EN: when defined, source 0 has strict priority in IDLE; sources 1..NUM_SRC-1 are round-robin among themselves. The pointer never selects 0. Grants are still packet-locked, with no preemption. When undefined, all sources are plain round-robin.

Test Plan:
- Reset then idle: reset_n=1 for 2 cycles, then 0 with no valids -> s_axis_ready=0, grant_valid=0, occupancy=0, f_rd_en=0.
- Single packet: src2 sends 4 beats 0xA0..0xA3 with last on 0xA3, f_ready=1 -> grant_id=2 one cycle after valid, 4 f_wr_en pulses, f_last on 0xA3, occupancy=4, back to IDLE, pointer=3.
- Round-robin fairness: src0 and src1 continuously valid with 2-beat packets -> grant order 0,1,0,1; one idle cycle between packets.
- Truncation with MAX_PKT_LEN=4: src1 sends 6 beats with last on beat 6 -> f_last forced on beat 4, pkt_err=1; beats 5-6 go out as a new packet after re-grant.
- Full backpressure: f_full=1 mid-packet for 5 cycles -> s_axis_ready=0, no f_wr_en, grant held; transfer resumes with no beats lost.
- Read/occupancy: occupancy=10, m_ready=1, f_empty=0, with simultaneous writes -> occupancy unchanged; enable=0 forces f_rd_en=0.
